dcache_mem_bridge: RTL
======================

Name: dcache_mem_bridge

Overview:
- Memory-side stage directly downstream of the data cache. Consumes the cache's write-back and refill requests and answers each with a one-cycle ready pulse.
- Posts write-backs into a small write buffer and drains them to the external word bus in the background.
- Serves refills either by forwarding from the write buffer or by a bus read.
- Gives refill reads priority over buffered writes whenever no address hazard exists.

Parameters:
- WB_DEPTH, 4, number of write-buffer entries (power of 2, >=2).
- ADDR_W, 32, address width.
- DATA_W, 32, data word width.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- cache_read  input  1  refill request; held with cache_addr stable until cache_ready.
- cache_write  input  1  write-back request; held with cache_addr/cache_wdata stable until cache_ready.
- cache_addr  input  ADDR_W  word address; bits [1:0] ignored.
- cache_wdata  input  DATA_W  write-back data.
- cache_rdata  output  DATA_W  refill data, valid in the cache_ready cycle of a read.
- cache_ready  output  1  one-cycle completion pulse for the current request.
- bus_req  output  1  external bus request.
- bus_we  output  1  1 = write, 0 = read.
- bus_addr  output  ADDR_W  bus address.
- bus_wdata  output  DATA_W  bus write data.
- bus_rdata  input  DATA_W  bus read data, valid with bus_ack on reads.
- bus_ack  input  1  bus completion, single-cycle.
- wb_empty  output  1  write buffer holds no entries.
- wb_full  output  1  write buffer holds WB_DEPTH entries.

Behaviour:
- Reset (reset low, asynchronous):
  - Outputs: cache_ready=0, cache_rdata=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, wb_empty=1, wb_full=0.
  - FIFO pointers and count are cleared; FSM goes to IDLE.
  - Reset mid-transaction abandons the transaction with no further bus_req. A late bus_ack is ignored.
- Write buffer:
  - Circular FIFO with count register of width log2(WB_DEPTH)+1. Pointers wrap modulo WB_DEPTH.
  - wb_full is asserted when count==WB_DEPTH; wb_empty when count==0. Both are registered.
- Write acceptance (independent of FSM):
  - cache_write is accepted when the FIFO is not full or a drain completes in the same cycle.
  - Acceptance enqueues {addr,wdata} and makes cache_ready=1 the next cycle.
  - cache_write stalls while full. Enqueue and dequeue in the same cycle leave count unchanged.
  - If cache_read and cache_write are both high, the write is serviced first; the read is evaluated the cycle after the write's ready.
- Read hazard check: compare cache_addr[ADDR_W-1:2] against all valid entries.
  - Match: forward the youngest matching entry's data. cache_ready=1 and cache_rdata set the next cycle (latency 1), with no bus access.
  - No match: issue a bus read.
- FSM states: IDLE, RD_BUS, WR_BUS, RD_RESP.
  - IDLE, unmatched cache_read pending (not yet readied): set bus_req=1, bus_we=0, bus_addr=cache_addr & ~3. Go to RD_BUS.
  - IDLE, else if FIFO non-empty: present the head entry on bus_req=1, bus_we=1. Go to WR_BUS.
  - RD_BUS on bus_ack: capture bus_rdata into cache_rdata, bus_req=0. Go to RD_RESP.
  - RD_RESP: cache_ready=1 for one cycle, then IDLE.
  - WR_BUS on bus_ack: dequeue head, bus_req=0. Go to IDLE. A pending read is therefore serviced before the next drain.
- Bus signals are held stable while bus_req=1 and no bus_ack.
- bus_req is low for at least one cycle between transactions.
- Read-miss latency is bus_ack cycle + 1 to cache_ready.
- A write accepted while in RD_BUS is enqueued normally; it cannot alias the read in flight because the hazard check already missed.
- cache_ready never asserts in two consecutive cycles for the same held request. The requester drops its request in the cycle after ready.

Test Plan:
- Reset release, then cache_write addr=0x100 data=0xDEADBEEF -> cache_ready next cycle, wb_empty=0. Bus write to 0x100 follows; bus_ack 3 cycles later -> wb_empty=1.
- Enqueue 4 writes with bus_ack withheld -> wb_full=1. 5th write stalls; ack the drain -> 5th accepted in the same cycle, wb_full stays 1.
- Buffer 0x200=0x11 then 0x200=0x22 with ack withheld; cache_read 0x200 -> cache_rdata=0x22 next cycle, bus_req unchanged.
- Buffer writes to 0x300; cache_read 0x400 -> bus read 0x400 issued before any drain. bus_rdata=0xCAFEF00D with ack -> cache_ready and data the next cycle.
- cache_read and cache_write to 0x500 in the same cycle -> write readied first, then read forwards the written data.
- Assert reset during RD_BUS -> bus_req=0 immediately, FIFO empty, a subsequent bus_ack produces no cache_ready.

Source files
------------

// File: rtl/dcache_mem_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_mem_bridge
//  Description : Memory-side stage behind the data cache. Write-backs are
//                posted into a circular write buffer and drained to the word
//                bus in the background; refills are forwarded from the buffer
//                on an address hit or fetched with a bus read, which takes
//                priority over pending drains.
//  Revision    : 1.0  initial release
// ============================================================================
module dcache_mem_bridge #(
    parameter int WB_DEPTH = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cache_read,
    input  logic              cache_write,
    input  logic [ADDR_W-1:0] cache_addr,
    input  logic [DATA_W-1:0] cache_wdata,
    output logic [DATA_W-1:0] cache_rdata,
    output logic              cache_ready,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    output logic              wb_empty,
    output logic              wb_full
);

    localparam int PTR_W = $clog2(WB_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TAG_W = ADDR_W - 2;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WB_DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_BUS  = 2'd1,
        WR_BUS  = 2'd2,
        RD_RESP = 2'd3
    } state_t;

    // Write buffer storage (word addresses only) and control
    logic [TAG_W-1:0]  r_wb_addr [WB_DEPTH];
    logic [DATA_W-1:0] r_wb_data [WB_DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_nxt;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              w_enq;
    logic              w_deq;
    logic              w_rd_pend;
    logic              w_hit;
    logic              w_fwd;
    logic [DATA_W-1:0] w_hit_data;
    logic [PTR_W-1:0]  w_idx;

    logic              w_ready_nxt;
    logic [DATA_W-1:0] w_rdata_nxt;
    logic              w_req_nxt;
    logic              w_we_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [DATA_W-1:0] w_wdata_nxt;

    // Byte-offset bits of the cache address carry no meaning on a word bus
    logic              w_unused_addr_lsbs;
    assign w_unused_addr_lsbs = ^cache_addr[1:0];

    // The drain retires on the bus ack; a write may take the freed slot in the
    // same cycle. The ready cycle itself never accepts, so a held request
    // cannot be completed twice.
    assign w_deq     = (r_state == WR_BUS) && bus_ack;
    assign w_enq     = cache_write && !cache_ready && (!wb_full || w_deq);
    assign w_rd_pend = cache_read && !cache_write && !cache_ready;
    assign w_fwd     = w_rd_pend && w_hit && ((r_state == IDLE) || (r_state == WR_BUS));

    // Hazard scan from oldest to youngest so the youngest match wins
    always_comb begin
        w_hit      = 1'b0;
        w_hit_data = '0;
        w_idx      = '0;
        for (int k = 0; k < WB_DEPTH; k++) begin
            w_idx = r_head + PTR_W'(k);
            if ((CNT_W'(k) < r_count) && (r_wb_addr[w_idx] == cache_addr[ADDR_W-1:2])) begin
                w_hit      = 1'b1;
                w_hit_data = r_wb_data[w_idx];
            end
        end
    end

    // Occupancy update; simultaneous enqueue and dequeue cancel out
    always_comb begin
        w_count_nxt = r_count;
        case ({w_enq, w_deq})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Next-state and registered-output decode; reads win over drains in IDLE
    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = bus_req;
        w_we_nxt    = bus_we;
        w_addr_nxt  = bus_addr;
        w_wdata_nxt = bus_wdata;
        w_ready_nxt = w_enq || w_fwd;
        w_rdata_nxt = w_fwd ? w_hit_data : cache_rdata;
        case (r_state)
            IDLE: begin
                if (w_rd_pend && !w_hit) begin
                    w_req_nxt   = 1'b1;
                    w_we_nxt    = 1'b0;
                    w_addr_nxt  = {cache_addr[ADDR_W-1:2], 2'b00};
                    w_state_nxt = RD_BUS;
                end else if (r_count != '0) begin
                    w_req_nxt   = 1'b1;
                    w_we_nxt    = 1'b1;
                    w_addr_nxt  = {r_wb_addr[r_head], 2'b00};
                    w_wdata_nxt = r_wb_data[r_head];
                    w_state_nxt = WR_BUS;
                end
            end
            RD_BUS: begin
                if (bus_ack) begin
                    w_req_nxt   = 1'b0;
                    w_rdata_nxt = bus_rdata;
                    w_ready_nxt = 1'b1;
                    w_state_nxt = RD_RESP;
                end
            end
            RD_RESP: begin
                w_state_nxt = IDLE;
            end
            WR_BUS: begin
                if (bus_ack) begin
                    w_req_nxt   = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_req_nxt   = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and bus/cache output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            cache_ready <= 1'b0;
            cache_rdata <= '0;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_wdata   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            cache_ready <= w_ready_nxt;
            cache_rdata <= w_rdata_nxt;
            bus_req     <= w_req_nxt;
            bus_we      <= w_we_nxt;
            bus_addr    <= w_addr_nxt;
            bus_wdata   <= w_wdata_nxt;
        end
    end

    // Write buffer pointers, count and status flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            wb_empty <= 1'b1;
            wb_full  <= 1'b0;
        end else begin
            if (w_enq) r_tail <= r_tail + PTR_W'(1);
            if (w_deq) r_head <= r_head + PTR_W'(1);
            r_count  <= w_count_nxt;
            wb_empty <= (w_count_nxt == '0);
            wb_full  <= (w_count_nxt == FULL_CNT);
        end
    end

    // Write buffer payload; contents are only meaningful under the count
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_wb_addr[r_tail] <= cache_addr[ADDR_W-1:2];
            r_wb_data[r_tail] <= cache_wdata;
        end
    end

endmodule
`default_nettype wire
